// File: rtl/frame_hdr_pkg.sv
// ============================================================================
// Package : frame_hdr_pkg
// Shared types, constants and byte-enable helpers for frame_header_inserter.
// Optional build macro: FHI_PAD_EN (adds the PAD state).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_hdr_pkg;

  localparam int unsigned DW    = 512;
  localparam int unsigned BYTES = DW / 8;
  localparam int unsigned POP_W = $clog2(BYTES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    HDRDROP = 3'd2,
    PAY     = 3'd3,
    DRAIN   = 3'd4
`ifdef FHI_PAD_EN
    ,
    PAD     = 3'd5
`endif
  } fhi_state_e;

  function automatic logic [POP_W-1:0] popcount_keep(input logic [BYTES-1:0] keep);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < BYTES; i++) begin
      n = n + POP_W'(keep[i]);
    end
    return n;
  endfunction

  function automatic logic [BYTES-1:0] keep_mask(input logic [POP_W-1:0] n);
    logic [BYTES-1:0] m;
    for (int i = 0; i < BYTES; i++) begin
      m[i] = (POP_W'(i) < n);
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_header_inserter_if.sv
// ============================================================================
// Interface : frame_header_inserter_if
// AXI-Stream beat bundle (data, keep, valid, ready, last) with master/slave views.
// Optional build macro: FHI_PAD_EN (unused here).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface frame_header_inserter_if #(
  parameter int DW = 512
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/frame_header_inserter_axis_out_reg.sv
// ============================================================================
// Module : axis_out_reg
// Single-stage AXI-Stream output register; payload held stable until accepted.
// Optional build macro: FHI_PAD_EN (unused here).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_out_reg #(
  parameter int DW = 512
) (
  input  wire logic            clk,
  input  wire logic            resetn,
  input  wire logic            push,
  input  wire logic [DW-1:0]   data,
  input  wire logic [DW/8-1:0] keep,
  input  wire logic            last,
  output logic                 can_load,
  output logic                 accept_last,
  frame_header_inserter_if.master m_axis
);

  assign can_load    = !m_axis.tvalid || m_axis.tready;
  assign accept_last = m_axis.tvalid && m_axis.tready && m_axis.tlast;

  // push is only asserted by the producer while can_load is high
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tkeep  <= '0;
      m_axis.tlast  <= 1'b0;
    end else if (push) begin
      m_axis.tvalid <= 1'b1;
      m_axis.tdata  <= data;
      m_axis.tkeep  <= keep;
      m_axis.tlast  <= last;
    end else if (m_axis.tready) begin
      m_axis.tvalid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_header_inserter.sv
// ============================================================================
// Module : frame_header_inserter
// Prepends a metadata header to each payload frame and enforces FRAME_SIZE.
// Optional build macro: FHI_PAD_EN (zero-pads short frames up to FRAME_SIZE).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_header_inserter
  import frame_hdr_pkg::*;
#(
  parameter int DW            = BYTES * 8,
  parameter int MAX_HDR_BEATS = 4,
  parameter int CNT_W         = 32
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  input  wire logic [31:0] FRAME_SIZE,
  frame_header_inserter_if.slave  s_axis_in,
  frame_header_inserter_if.slave  s_axis_md,
  frame_header_inserter_if.master m_axis_out,
  output logic             ERR_HDR,
  output logic             ERR_SHORT,
  output logic             ERR_LONG,
  output logic [31:0]      FRAME_CNT
);

  localparam int NB   = DW / 8;
  localparam int HC_W = $clog2(MAX_HDR_BEATS + 1);

  fhi_state_e        state, state_n;
  logic [CNT_W-1:0]  fs_q, fs_n;
  logic [CNT_W-1:0]  byte_cnt, bc_n;
  logic [HC_W-1:0]   hdr_cnt, hc_n;
  logic              ehdr_n, eshort_n, elong_n;

  logic              push, can_load, accept_last;
  logic [DW-1:0]     o_data;
  logic [NB-1:0]     o_keep;
  logic              o_last;
  logic              in_ready, md_ready;

  logic [POP_W-1:0]  w_pop;
  logic [CNT_W:0]    w_sum;
  logic [CNT_W-1:0]  w_new;
  logic [CNT_W-1:0]  w_rem;
  logic [POP_W-1:0]  w_rem_n;
  logic [NB-1:0]     w_mask;

  assign s_axis_in.tready = in_ready;
  assign s_axis_md.tready = md_ready;

  // saturating running byte count and the bytes still owed to fs_q
  assign w_pop   = popcount_keep(BYTES'(s_axis_in.tkeep));
  assign w_sum   = {1'b0, byte_cnt} + (CNT_W+1)'(w_pop);
  assign w_new   = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  assign w_rem   = fs_q - byte_cnt;
  assign w_rem_n = (w_rem > CNT_W'(NB)) ? POP_W'(NB) : w_rem[POP_W-1:0];
  assign w_mask  = NB'(keep_mask(w_rem_n));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      fs_q      <= '0;
      byte_cnt  <= '0;
      hdr_cnt   <= '0;
      ERR_HDR   <= 1'b0;
      ERR_SHORT <= 1'b0;
      ERR_LONG  <= 1'b0;
      FRAME_CNT <= '0;
    end else begin
      state     <= state_n;
      fs_q      <= fs_n;
      byte_cnt  <= bc_n;
      hdr_cnt   <= hc_n;
      ERR_HDR   <= ehdr_n;
      ERR_SHORT <= eshort_n;
      ERR_LONG  <= elong_n;
      if (accept_last) begin
        FRAME_CNT <= FRAME_CNT + 32'd1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    fs_n     = fs_q;
    bc_n     = byte_cnt;
    hc_n     = hdr_cnt;
    ehdr_n   = 1'b0;
    eshort_n = 1'b0;
    elong_n  = 1'b0;
    push     = 1'b0;
    o_data   = '0;
    o_keep   = '0;
    o_last   = 1'b0;
    in_ready = 1'b0;
    md_ready = 1'b0;

    unique case (state)
      IDLE: begin
        if (s_axis_md.tvalid) begin
          state_n = HDR;
          fs_n    = CNT_W'(FRAME_SIZE);
          bc_n    = '0;
          hc_n    = '0;
        end
      end

      HDR: begin
        md_ready = can_load;
        if (s_axis_md.tvalid && can_load) begin
          push   = 1'b1;
          o_data = s_axis_md.tdata;
          o_keep = '1;
          hc_n   = hdr_cnt + HC_W'(1);
          if (s_axis_md.tlast) begin
            state_n = PAY;
          end else if (hdr_cnt == HC_W'(MAX_HDR_BEATS - 1)) begin
            ehdr_n  = 1'b1;
            state_n = HDRDROP;
          end
        end
      end

      HDRDROP: begin
        md_ready = 1'b1;
        if (s_axis_md.tvalid && s_axis_md.tlast) begin
          state_n = PAY;
        end
      end

      PAY: begin
        in_ready = can_load;
        if (s_axis_in.tvalid && can_load) begin
          push   = 1'b1;
          o_data = s_axis_in.tdata;
          o_keep = s_axis_in.tkeep;
          o_last = s_axis_in.tlast;
          bc_n   = w_new;
          if (fs_q == '0) begin
            if (s_axis_in.tlast) begin
              state_n = IDLE;
            end
          end else if (w_new >= fs_q) begin
            o_keep  = s_axis_in.tkeep & w_mask;
            o_last  = 1'b1;
            elong_n = (w_new != fs_q) || !s_axis_in.tlast;
            state_n = s_axis_in.tlast ? IDLE : DRAIN;
          end else if (s_axis_in.tlast) begin
            eshort_n = 1'b1;
`ifdef FHI_PAD_EN
            o_last   = 1'b0;
            state_n  = PAD;
`else
            state_n  = IDLE;
`endif
          end
        end
      end

      DRAIN: begin
        in_ready = 1'b1;
        if (s_axis_in.tvalid && s_axis_in.tlast) begin
          state_n = IDLE;
        end
      end

`ifdef FHI_PAD_EN
      PAD: begin
        if (can_load) begin
          push = 1'b1;
          if (w_rem <= CNT_W'(NB)) begin
            o_keep  = w_mask;
            o_last  = 1'b1;
            state_n = IDLE;
          end else begin
            o_keep = '1;
            bc_n   = byte_cnt + CNT_W'(NB);
          end
        end
      end
`endif

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  axis_out_reg #(
    .DW (DW)
  ) u_out_reg (
    .clk         (clk),
    .resetn      (resetn),
    .push        (push),
    .data        (o_data),
    .keep        (o_keep),
    .last        (o_last),
    .can_load    (can_load),
    .accept_last (accept_last),
    .m_axis      (m_axis_out)
  );

endmodule

`default_nettype wire
